axi_master_arbiter: RTL and testbench

Two-port AXI4 master front end for the ysyx_22050518 core. It arbitrates instruction-cache line refills and data-cache refills, writebacks and uncached accesses onto the single `io_master_*` AXI4 port that drives the SoC memory slave. It runs one transaction at a time, generates burst length, size, ID and WLAST, counts beats, and returns read data and completion status to the owning requester.

---
 rtl/axi_master_arbiter.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_master_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_arbiter.sv
// Two-port (I-cache / D-cache) AXI4 master front end, one transaction at a time, read data passed through with zero latency.
// Requests wait in IDLE until granted; define ARB_RR_EN for round-robin arbitration instead of fixed D-over-I priority.
`timescale 1ns/1ps
module axi_master_arbiter #(
  parameter int         LINE_BEATS = 2,
  parameter logic [3:0] ID_I       = 4'd0,
  parameter logic [3:0] ID_D       = 4'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic [63:0] i_rdata,
  output logic        i_rvalid,
  output logic        i_rlast,
  output logic        i_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_write,
  input  logic        d_req_single,
  input  logic [2:0]  d_req_size,
  input  logic [31:0] d_req_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wstrb,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic [63:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_rlast,
  output logic        d_done,
  output logic        d_err,
  input  logic        io_master_awready,
  output logic        io_master_awvalid,
  output logic [3:0]  io_master_awid,
  output logic [31:0] io_master_awaddr,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_wready,
  output logic        io_master_wvalid,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  output logic        io_master_bready,
  input  logic        io_master_bvalid,
  input  logic [3:0]  io_master_bid,
  input  logic [1:0]  io_master_bresp,
  input  logic        io_master_arready,
  output logic        io_master_arvalid,
  output logic [3:0]  io_master_arid,
  output logic [31:0] io_master_araddr,
  output logic [7:0]  io_master_arlen,
  output logic [2:0]  io_master_arsize,
  output logic [1:0]  io_master_arburst,
  output logic        io_master_rready,
  input  logic        io_master_rvalid,
  input  logic [3:0]  io_master_rid,
  input  logic [1:0]  io_master_rresp,
  input  logic [63:0] io_master_rdata,
  input  logic        io_master_rlast
);

  localparam int              CW        = $clog2(LINE_BEATS) + 1;
  localparam logic [7:0]      BURST_LEN = 8'(LINE_BEATS - 1);
  localparam logic [CW-1:0]   CNT_MAX   = CW'(LINE_BEATS);

  typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

  state_t        state, nxt;
  logic          owner_d;
  logic          aw_done, w_done, err_acc;
  logic [2:0]    size_r;
  logic [31:0]   addr_r;
  logic [7:0]    len_r;
  logic [CW-1:0] cnt;
  logic          take, grant_d, grant_single;
  logic          last_beat, r_bad, w_hs;
  logic [3:0]    owner_id;
  logic          unused_ok;

  assign unused_ok         = ^{io_master_bid, io_master_rid};
  assign io_master_awburst = 2'b01;
  assign io_master_arburst = 2'b01;

  assign take = d_req_valid | i_req_valid;
`ifdef ARB_RR_EN
  logic last_d;
  // On a tie the port that was not served last wins.
  assign grant_d = d_req_valid & (~i_req_valid | ~last_d);
`else
  assign grant_d = d_req_valid;
`endif
  assign grant_single = grant_d & d_req_single;

  assign owner_id  = owner_d ? ID_D : ID_I;
  assign last_beat = (8'(cnt) == len_r);
  // A burst is bad if any beat errored or rlast lands on the wrong beat index.
  assign r_bad     = err_acc | (io_master_rresp != 2'b00) | ~last_beat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_acc <= 1'b0;
      size_r  <= 3'd0;
      addr_r  <= 32'd0;
      len_r   <= 8'd0;
      cnt     <= '0;
`ifdef ARB_RR_EN
      last_d  <= 1'b0;
`endif
    end else begin
      state <= nxt;
      case (state)
        IDLE: if (take) begin
          owner_d <= grant_d;
          size_r  <= grant_single ? d_req_size : 3'd3;
          len_r   <= grant_single ? 8'd0 : BURST_LEN;
          addr_r  <= grant_d ? d_req_addr : i_req_addr;
          cnt     <= '0;
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          err_acc <= 1'b0;
`ifdef ARB_RR_EN
          last_d  <= grant_d;
`endif
        end
        R: if (io_master_rvalid) begin
          if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
          if (io_master_rresp != 2'b00) err_acc <= 1'b1;
        end
        W: begin
          if (io_master_awvalid && io_master_awready) aw_done <= 1'b1;
          if (w_hs) begin
            if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
            if (io_master_wlast) w_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt               = state;
    i_req_ready       = 1'b0;
    d_req_ready       = 1'b0;
    i_rdata           = 64'd0;
    i_rvalid          = 1'b0;
    i_rlast           = 1'b0;
    i_err             = 1'b0;
    d_wready          = 1'b0;
    d_rdata           = 64'd0;
    d_rvalid          = 1'b0;
    d_rlast           = 1'b0;
    d_done            = 1'b0;
    d_err             = 1'b0;
    io_master_awvalid = 1'b0;
    io_master_awid    = 4'd0;
    io_master_awaddr  = 32'd0;
    io_master_awlen   = 8'd0;
    io_master_awsize  = 3'd0;
    io_master_wvalid  = 1'b0;
    io_master_wdata   = 64'd0;
    io_master_wstrb   = 8'd0;
    io_master_wlast   = 1'b0;
    io_master_bready  = 1'b0;
    io_master_arvalid = 1'b0;
    io_master_arid    = 4'd0;
    io_master_araddr  = 32'd0;
    io_master_arlen   = 8'd0;
    io_master_arsize  = 3'd0;
    io_master_rready  = 1'b0;
    w_hs              = 1'b0;
    case (state)
      IDLE: if (take) begin
        d_req_ready = grant_d;
        i_req_ready = ~grant_d;
        nxt         = (grant_d && d_req_write) ? W : AR;
      end
      AR: begin
        io_master_arvalid = 1'b1;
        io_master_arid    = owner_id;
        io_master_araddr  = addr_r;
        io_master_arlen   = len_r;
        io_master_arsize  = size_r;
        if (io_master_arready) nxt = R;
      end
      R: begin
        io_master_rready = 1'b1;
        if (owner_d) begin
          d_rvalid = io_master_rvalid;
          d_rdata  = io_master_rdata;
          d_rlast  = io_master_rvalid & io_master_rlast;
          d_done   = io_master_rvalid & io_master_rlast;
          d_err    = io_master_rvalid & io_master_rlast & r_bad;
        end else begin
          i_rvalid = io_master_rvalid;
          i_rdata  = io_master_rdata;
          i_rlast  = io_master_rvalid & io_master_rlast;
          i_err    = io_master_rvalid & io_master_rlast & r_bad;
        end
        if (io_master_rvalid && io_master_rlast) nxt = IDLE;
      end
      W: begin
        // AW and W proceed independently; W beats may finish before AW is accepted.
        io_master_awvalid = ~aw_done;
        io_master_awid    = owner_id;
        io_master_awaddr  = addr_r;
        io_master_awlen   = len_r;
        io_master_awsize  = size_r;
        io_master_wvalid  = d_wvalid & ~w_done;
        d_wready          = io_master_wready & ~w_done;
        io_master_wdata   = d_wdata;
        io_master_wstrb   = d_wstrb;
        io_master_wlast   = ~w_done & last_beat;
        w_hs              = io_master_wvalid & io_master_wready;
        if ((w_done || (w_hs && io_master_wlast)) && (aw_done || io_master_awready))
          nxt = B;
      end
      B: begin
        io_master_bready = 1'b1;
        if (io_master_bvalid) begin
          d_done = 1'b1;
          d_err  = (io_master_bresp != 2'b00);
          nxt    = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter.sv
// Scoreboard bench for axi_master_arbiter: expected grants, read beats and write completions are queued as stimulus is driven.
`timescale 1ns/1ps
module tb_axi_master_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        i_req_valid = 0, i_req_ready;
  logic [31:0] i_req_addr = 0;
  logic [63:0] i_rdata;
  logic        i_rvalid, i_rlast, i_err;
  logic        d_req_valid = 0, d_req_ready, d_req_write = 0, d_req_single = 0;
  logic [2:0]  d_req_size = 0;
  logic [31:0] d_req_addr = 0;
  logic [63:0] d_wdata = 0;
  logic [7:0]  d_wstrb = 0;
  logic        d_wvalid = 0, d_wready;
  logic [63:0] d_rdata;
  logic        d_rvalid, d_rlast, d_done, d_err;
  logic        awready = 0, awvalid;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wready = 0, wvalid, wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        bready, bvalid = 0;
  logic [3:0]  bid = 0;
  logic [1:0]  bresp = 0;
  logic        arready = 0, arvalid;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rready, rvalid = 0, rlast = 0;
  logic [3:0]  rid = 0;
  logic [1:0]  rresp = 0;
  logic [63:0] rdata = 0;

  axi_master_arbiter dut (
    .clock(clock), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rdata(i_rdata), .i_rvalid(i_rvalid), .i_rlast(i_rlast), .i_err(i_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
    .d_req_single(d_req_single), .d_req_size(d_req_size), .d_req_addr(d_req_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_rlast(d_rlast), .d_done(d_done), .d_err(d_err),
    .io_master_awready(awready), .io_master_awvalid(awvalid), .io_master_awid(awid),
    .io_master_awaddr(awaddr), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wready(wready), .io_master_wvalid(wvalid), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bready(bready), .io_master_bvalid(bvalid), .io_master_bid(bid), .io_master_bresp(bresp),
    .io_master_arready(arready), .io_master_arvalid(arvalid), .io_master_arid(arid),
    .io_master_araddr(araddr), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rready(rready), .io_master_rvalid(rvalid), .io_master_rid(rid),
    .io_master_rresp(rresp), .io_master_rdata(rdata), .io_master_rlast(rlast)
  );

  // OR of every output except the constant burst fields.
  logic out_or;
  assign out_or = |{i_req_ready, i_rdata, i_rvalid, i_rlast, i_err, d_req_ready, d_wready,
                    d_rdata, d_rvalid, d_rlast, d_done, d_err, awvalid, awid, awaddr, awlen,
                    awsize, wvalid, wdata, wstrb, wlast, bready, arvalid, arid, araddr, arlen,
                    arsize, rready};

  typedef struct {
    int          kind;   // 0 grant, 1 read beat, 2 write completion
    int          port;   // 0 I-cache, 1 D-cache
    logic [63:0] data;
    logic        last;
    logic        err;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int kind, input int port, input logic [63:0] data,
                      input logic last, input logic err);
    ev_t e;
    e.kind = kind; e.port = port; e.data = data; e.last = last; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind, input int port, input logic [63:0] data,
                         input logic last, input logic err);
    ev_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_event", 64'(kind), 64'd99);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_kind", 64'(kind), 64'(e.kind));
    chk("sb_port", 64'(port), 64'(e.port));
    if (e.kind == 1) begin
      chk("sb_rdata", data, e.data);
      chk("sb_rlast", 64'(last), 64'(e.last));
      chk("sb_rerr", 64'(err), 64'(e.err));
    end else if (e.kind == 2) begin
      chk("sb_berr", 64'(err), 64'(e.err));
    end
  endtask

  initial forever begin
    @(negedge clock);
    if (i_req_ready) pop_cmp(0, 0, 64'd0, 1'b0, 1'b0);
    if (d_req_ready) pop_cmp(0, 1, 64'd0, 1'b0, 1'b0);
    if (i_rvalid) pop_cmp(1, 0, i_rdata, i_rlast, i_err);
    if (d_rvalid) begin
      pop_cmp(1, 1, d_rdata, d_rlast, d_err);
      chk("d_done_with_rlast", 64'(d_done), 64'(d_rlast));
    end else if (d_done) begin
      pop_cmp(2, 1, 64'd0, 1'b0, d_err);
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic grant(input int port, input logic wr, input logic single,
                       input logic [2:0] size, input logic [31:0] addr);
    int n;
    push(0, port, 64'd0, 1'b0, 1'b0);
    if (port == 0) begin
      i_req_valid = 1; i_req_addr = addr;
    end else begin
      d_req_valid = 1; d_req_write = wr; d_req_single = single;
      d_req_size = size; d_req_addr = addr;
    end
    #1;
    n = 0;
    while (!(port == 0 ? i_req_ready : d_req_ready) && n < 50) begin
      step; #1; n++;
    end
    chk("grant_within_budget", 64'(n < 50), 64'd1);
    step;
    i_req_valid = 0;
    d_req_valid = 0;
  endtask

  // Slave side of one read: AR handshake, then beats 0..last_idx with rlast on last_idx.
  task automatic serve_read(input int port, input logic [31:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input int last_idx, input logic [1:0] resp);
    int          n;
    logic [63:0] d;
    logic        experr;
    #1;
    n = 0;
    while (!arvalid && n < 20) begin
      step; #1; n++;
    end
    chk("arvalid_within_budget", 64'(n < 20), 64'd1);
    chk("araddr", 64'(araddr), 64'(addr));
    chk("arlen", 64'(arlen), 64'(len));
    chk("arsize", 64'(arsize), 64'(size));
    chk("arid", 64'(arid), (port == 0) ? 64'd0 : 64'd1);
    arready = 1;
    step;
    arready = 0;
    experr = (resp != 2'b00) || (last_idx != int'(len));
    for (int b = 0; b <= last_idx; b++) begin
      d = {addr, 32'(b)} ^ 64'h5a5a_0000_0000_a5a5;
      rvalid = 1; rdata = d; rresp = resp; rlast = (b == last_idx);
      rid = (port == 0) ? 4'd0 : 4'd1;
      push(1, port, d, b == last_idx, (b == last_idx) ? experr : 1'b0);
      step;
    end
    rvalid = 0; rlast = 0; rresp = 0;
    #1;
    chk("idle_after_read_rready", 64'(rready), 64'd0);
    chk("idle_after_read_arvalid", 64'(arvalid), 64'd0);
  endtask

  initial begin
    int   beat, bcyc, pi, pd, n;
    logic exp_d, last_d, obs_d;

    #1 reset = 0;
    #1;
    chk("reset_outputs_zero", 64'(out_or), 64'd0);
    chk("reset_arburst", 64'(arburst), 64'd1);
    chk("reset_awburst", 64'(awburst), 64'd1);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    step;

    // I-cache line refill, zero-wait slave.
    grant(0, 1'b0, 1'b0, 3'd0, 32'h8000_0000);
    serve_read(0, 32'h8000_0000, 8'd1, 3'd3, 1, 2'b00);

    // Both ports request three times each, re-requesting as soon as served.
    pi = 3; pd = 3; last_d = 1'b0;
    i_req_addr = 32'h8000_1000; d_req_addr = 32'h8000_2000;
    d_req_write = 0; d_req_single = 0;
    i_req_valid = 1; d_req_valid = 1;
    for (int k = 0; k < 6; k++) begin
`ifdef ARB_RR_EN
      exp_d = (pd > 0 && pi > 0) ? ~last_d : (pd > 0);
`else
      exp_d = (pd > 0);
`endif
      last_d = exp_d;
      push(0, exp_d ? 1 : 0, 64'd0, 1'b0, 1'b0);
      #1;
      n = 0;
      while (!(i_req_ready || d_req_ready) && n < 50) begin
        step; #1; n++;
      end
      chk("arb_grant_within_budget", 64'(n < 50), 64'd1);
      if (n >= 50) break;
      obs_d = d_req_ready;
      step;
      if (obs_d) begin
        pd--;
        if (pd <= 0) d_req_valid = 0;
      end else begin
        pi--;
        if (pi <= 0) i_req_valid = 0;
      end
      serve_read(obs_d ? 1 : 0, obs_d ? 32'h8000_2000 : 32'h8000_1000, 8'd1, 3'd3, 1, 2'b00);
    end
    i_req_valid = 0; d_req_valid = 0;

    // D-cache line writeback, awready held low for 3 cycles while wready is high.
    grant(1, 1'b1, 1'b0, 3'd0, 32'h8000_0100);
    beat = 0; bcyc = -1;
    for (int c = 0; c < 12; c++) begin
      awready = (c == 3); wready = 1;
      d_wvalid = (beat < 2); d_wdata = 64'h1111_0000_0000_0000 + 64'(beat); d_wstrb = 8'hff;
      #1;
      if (bready) begin
        bcyc = c;
        break;
      end
      if (c == 0) begin
        chk("awvalid_first", 64'(awvalid), 64'd1);
        chk("awaddr", 64'(awaddr), 64'h8000_0100);
        chk("awlen", 64'(awlen), 64'd1);
        chk("awsize", 64'(awsize), 64'd3);
        chk("awid", 64'(awid), 64'd1);
      end
      if (c == 2) chk("awvalid_held", 64'(awvalid), 64'd1);
      if (wvalid && wready) begin
        chk("wdata", wdata, 64'h1111_0000_0000_0000 + 64'(beat));
        chk("wlast", 64'(wlast), 64'(beat == 1));
        chk("d_wready", 64'(d_wready), 64'd1);
        beat++;
      end
      step;
    end
    awready = 0; wready = 0; d_wvalid = 0;
    chk("w_beats_accepted", 64'(beat), 64'd2);
    chk("b_entry_cycle", 64'(bcyc), 64'd4);
    push(2, 1, 64'd0, 1'b0, 1'b0);
    bvalid = 1; bresp = 2'b00; bid = 4'd1;
    #1;
    chk("d_done_on_bvalid", 64'(d_done), 64'd1);
    step;
    bvalid = 0;
    #1;
    chk("d_done_one_cycle", 64'(d_done), 64'd0);
    chk("idle_after_write_bready", 64'(bready), 64'd0);

    // Single-beat MMIO read with SLVERR.
    grant(1, 1'b0, 1'b1, 3'd2, 32'h1000_0004);
    serve_read(1, 32'h1000_0004, 8'd0, 3'd2, 0, 2'b10);

    // Slave ends a 2-beat burst after one beat.
    grant(0, 1'b0, 1'b0, 3'd0, 32'h8000_0040);
    serve_read(0, 32'h8000_0040, 8'd1, 3'd3, 0, 2'b00);

    // Reset during the first read beat.
    grant(0, 1'b0, 1'b0, 3'd0, 32'h8000_0080);
    #1;
    chk("arvalid_before_reset", 64'(arvalid), 64'd1);
    arready = 1;
    step;
    arready = 0;
    rvalid = 1; rdata = 64'hdead_beef_0000_0001; rlast = 0;
    reset = 0;
    #1;
    chk("mid_reset_outputs_zero", 64'(out_or), 64'd0);
    chk("mid_reset_arburst", 64'(arburst), 64'd1);
    rvalid = 0; rdata = 0;
    step;
    reset = 1;
    step;
    grant(0, 1'b0, 1'b0, 3'd0, 32'h8000_00c0);
    serve_read(0, 32'h8000_00c0, 8'd1, 3'd3, 1, 2'b00);

    step;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
